// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
// Holds the FSM state encoding, the LFSR feedback taps and the seed constants.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_SAMPLE,
        ST_RELAX
    } state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED  = 8'hA5;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // Fibonacci step: taps B8 select bits 7,5,4,3, feedback enters at the LSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] c);
        return {c[6:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Control/readout bus between the PUF sequencer and its host.
// The master modport is the host side; the slave modport is the sequencer.
interface puf_challenge_sequencer_if #(
    parameter int N_BITS = 16
);
    localparam int CNT_W = $clog2(N_BITS + 1);

    logic              start;
    logic              seed_load;
    logic [7:0]        seed;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] resp_word;
    logic [CNT_W-1:0]  unstable_cnt;

    modport master (
        output start, seed_load, seed,
        input  busy, done, resp_word, unstable_cnt
    );

    modport slave (
        input  start, seed_load, seed,
        output busy, done, resp_word, unstable_cnt
    );

endinterface

// File: rtl/puf_challenge_sequencer_lfsr.sv
// 8-bit Fibonacci LFSR that produces the PUF challenge.
// An all-zero load would lock the register, so it is replaced by a non-zero value.
module puf_lfsr8
    import puf_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       advance,
    output logic [7:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == 8'h00) ? ZERO_SEED_SUB : load_val;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences challenge/launch/clear for an arbiter PUF, synchronizes its response,
// majority-votes repeated races per challenge and packs the voted bits into a word.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int         N_BITS     = 16,
    parameter int         VOTE       = 5,
    parameter int         SETTLE_CYC = 8,
    parameter logic [7:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst,
    puf_challenge_sequencer_if.slave   ctrl,
    input  logic                       resp,
    output logic [7:0]                 ch,
    output logic                       mux_in,
    output logic                       puf_rst
);

    localparam int CNT_W  = $clog2(N_BITS + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC);
    localparam int VOTE_W = $clog2(VOTE + 1);
    localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    state_t             state;
    state_t             next_state;
    logic [SET_W-1:0]   set_cnt;
    logic [VOTE_W-1:0]  race_cnt;
    logic [VOTE_W-1:0]  ones_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sync1;
    logic               sync2;
    logic               start_pend;
    logic               busy_q;
    logic               done_q;
    logic [N_BITS-1:0]  resp_word_q;
    logic [CNT_W-1:0]   unstable_q;
    logic               mux_q;
    logic               puf_rst_q;

    logic set_last;
    logic race_last;
    logic bit_last;
    logic chal_end;
    logic run_end;
    logic vote_bit;
    logic split_vote;
    logic idle_free;
    logic accept;
    logic lfsr_load;

    assign set_last   = (set_cnt == SET_W'(SETTLE_CYC - 1));
    assign race_last  = (race_cnt == VOTE_W'(VOTE - 1));
    assign bit_last   = (bit_cnt == BIT_W'(N_BITS - 1));
    assign chal_end   = (state == ST_RELAX) && set_last && race_last;
    assign run_end    = chal_end && bit_last;
    assign vote_bit   = (ones_cnt > VOTE_W'(VOTE / 2));
    assign split_vote = (ones_cnt != '0) && (ones_cnt != VOTE_W'(VOTE));
    // A start is held for one cycle before the run begins; the LFSR is frozen meanwhile.
    assign idle_free  = (state == ST_IDLE) && !start_pend;
    assign accept     = idle_free && ctrl.start;
    assign lfsr_load  = idle_free && ctrl.seed_load;

    puf_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (ctrl.seed),
        .advance  (chal_end),
        .state    (ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start_pend) next_state = ST_CLEAR;
            ST_CLEAR:  next_state = ST_LAUNCH;
            ST_LAUNCH: if (set_last) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = ST_RELAX;
            ST_RELAX:  if (set_last) next_state = run_end ? ST_IDLE : ST_CLEAR;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= resp;
            sync2 <= sync1;
        end
    end

    // All counters return to zero at the end of a run, so IDLE needs no extra clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_cnt  <= '0;
            race_cnt <= '0;
            ones_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if ((state == ST_LAUNCH || state == ST_RELAX) && !set_last) begin
                set_cnt <= set_cnt + 1'b1;
            end else begin
                set_cnt <= '0;
            end
            if (state == ST_SAMPLE) begin
                ones_cnt <= ones_cnt + VOTE_W'(sync2);
            end
            if (state == ST_RELAX && set_last) begin
                if (race_last) begin
                    race_cnt <= '0;
                    ones_cnt <= '0;
                    bit_cnt  <= bit_last ? '0 : bit_cnt + 1'b1;
                end else begin
                    race_cnt <= race_cnt + 1'b1;
                end
            end
        end
    end

    // mux_in follows LAUNCH one cycle late so the launch edge always trails the clear release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_pend  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_word_q <= '0;
            unstable_q  <= '0;
            mux_q       <= 1'b0;
            puf_rst_q   <= 1'b1;
        end else begin
            start_pend <= accept;
            done_q     <= run_end;
            mux_q      <= (state == ST_LAUNCH);
            puf_rst_q  <= (next_state == ST_IDLE) || (next_state == ST_CLEAR);
            if (start_pend) begin
                busy_q      <= 1'b1;
                resp_word_q <= '0;
                unstable_q  <= '0;
            end else if (chal_end) begin
                resp_word_q <= (resp_word_q << 1) | N_BITS'(vote_bit);
                unstable_q  <= unstable_q + CNT_W'(split_vote);
                if (bit_last) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign mux_in            = mux_q;
    assign puf_rst           = puf_rst_q;
    assign ctrl.busy         = busy_q;
    assign ctrl.done         = done_q;
    assign ctrl.resp_word    = resp_word_q;
    assign ctrl.unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a behavioural PUF response model.
module tb_puf_challenge_sequencer;

    localparam int N_BITS  = 16;
    localparam int VOTE    = 5;
    localparam int SETTLE  = 8;
    localparam int RUN_CYC = N_BITS * VOTE * (2 * SETTLE + 2) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       resp;
    logic [7:0] ch;
    logic       mux_in;
    logic       puf_rst;

    int         checks = 0;
    int         errors = 0;
    int         done_pulses = 0;
    int         resp_mode = 0;
    logic       resp_const = 1'b0;
    int         race_idx = 0;
    logic       alt_bit = 1'b0;

    puf_challenge_sequencer_if #(.N_BITS(N_BITS)) bus ();

    puf_challenge_sequencer #(
        .N_BITS     (N_BITS),
        .VOTE       (VOTE),
        .SETTLE_CYC (SETTLE),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (bus),
        .resp    (resp),
        .ch      (ch),
        .mux_in  (mux_in),
        .puf_rst (puf_rst)
    );

    always #5 clk = ~clk;

    always @* begin
        case (resp_mode)
            0:       resp = resp_const;
            1:       resp = ch[0];
            default: resp = alt_bit;
        endcase
    end

    // Alternating model: races 0..4 of each challenge give 1,0,1,0,1.
    always @(posedge mux_in or posedge rst) begin
        if (rst) begin
            race_idx <= 0;
            alt_bit  <= 1'b0;
        end else begin
            alt_bit  <= (race_idx % 2 == 0);
            race_idx <= (race_idx == VOTE - 1) ? 0 : race_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (bus.done) done_pulses <= done_pulses + 1;
    end

    function automatic logic [7:0] lfsr_adv(input logic [7:0] c, input int n);
        logic [7:0] s;
        s = c;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    function automatic logic [15:0] ch0_word(input logic [7:0] seed);
        logic [7:0]  s;
        logic [15:0] w;
        s = seed;
        w = '0;
        for (int i = 0; i < N_BITS; i++) begin
            w = {w[14:0], s[0]};
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return w;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic load_seed(input logic [7:0] value);
        @(negedge clk);
        bus.seed_load = 1'b1;
        bus.seed      = value;
        @(negedge clk);
        bus.seed_load = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (c < RUN_CYC + 200) begin
            @(negedge clk);
            c++;
            if (bus.done) return;
        end
        c = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (ch !== 8'hA5) begin errors++; $display("[TB] FAIL reset_ch: got %h want a5", ch); end
        checks++; if (mux_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_mux_in: got %b want 0", mux_in); end
        checks++; if (puf_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_puf_rst: got %b want 1", puf_rst); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.resp_word !== 16'h0000) begin errors++; $display("[TB] FAIL reset_resp_word: got %h want 0000", bus.resp_word); end
        checks++; if (bus.unstable_cnt !== 5'd0) begin errors++; $display("[TB] FAIL reset_unstable: got %0d want 0", bus.unstable_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int c;
        int got;
        int p0;
        resp_mode  = 0;
        resp_const = 1'b1;
        p0 = done_pulses;
        pulse_start();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ones_busy_c0: got %b want 0", bus.busy); end
        c = 0;
        got = -1;
        while (c < RUN_CYC + 100 && got < 0) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL ones_busy_c1: got %b want 1", bus.busy); end
                checks++; if (puf_rst !== 1'b1) begin errors++; $display("[TB] FAIL ones_clear_puf_rst: got %b want 1", puf_rst); end
            end
            if (c == 2) begin
                checks++; if (puf_rst !== 1'b0 || mux_in !== 1'b0) begin errors++; $display("[TB] FAIL ones_launch_c2: got puf_rst=%b mux_in=%b want 0/0", puf_rst, mux_in); end
            end
            if (c == 3) begin
                checks++; if (mux_in !== 1'b1) begin errors++; $display("[TB] FAIL ones_mux_rise: got %b want 1", mux_in); end
            end
            if (c == 90) begin
                checks++; if (ch !== 8'hA5) begin errors++; $display("[TB] FAIL ones_ch_first: got %h want a5", ch); end
            end
            if (c == 91) begin
                checks++; if (ch !== 8'h4A) begin errors++; $display("[TB] FAIL ones_ch_second: got %h want 4a", ch); end
            end
            if (bus.done) got = c;
        end
        checks++; if (got != RUN_CYC) begin errors++; $display("[TB] FAIL ones_done_cycle: got %0d want %0d", got, RUN_CYC); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ones_busy_at_done: got %b want 0", bus.busy); end
        checks++; if (bus.resp_word !== 16'hFFFF) begin errors++; $display("[TB] FAIL ones_resp_word: got %h want ffff", bus.resp_word); end
        checks++; if (bus.unstable_cnt !== 5'd0) begin errors++; $display("[TB] FAIL ones_unstable: got %0d want 0", bus.unstable_cnt); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL ones_done_width: got %b want 0", bus.done); end
        checks++; if (done_pulses - p0 != 1) begin errors++; $display("[TB] FAIL ones_done_pulses: got %0d want 1", done_pulses - p0); end
        checks++; if (bus.resp_word !== 16'hFFFF) begin errors++; $display("[TB] FAIL ones_resp_hold: got %h want ffff", bus.resp_word); end
    endtask

    task automatic test_ch0_model();
        int c;
        logic [15:0] exp_word;
        resp_mode = 1;
        exp_word  = ch0_word(8'hA5);
        load_seed(8'hA5);
        checks++; if (ch !== 8'hA5) begin errors++; $display("[TB] FAIL ch0_seed: got %h want a5", ch); end
        pulse_start();
        wait_done(c);
        checks++; if (c != RUN_CYC) begin errors++; $display("[TB] FAIL ch0_done_cycle: got %0d want %0d", c, RUN_CYC); end
        checks++; if (bus.resp_word[15] !== 1'b1 || bus.resp_word[14] !== 1'b0) begin errors++; $display("[TB] FAIL ch0_msbs: got %b%b want 10", bus.resp_word[15], bus.resp_word[14]); end
        checks++; if (bus.resp_word !== exp_word) begin errors++; $display("[TB] FAIL ch0_resp_word: got %h want %h", bus.resp_word, exp_word); end
        checks++; if (bus.unstable_cnt !== 5'd0) begin errors++; $display("[TB] FAIL ch0_unstable: got %0d want 0", bus.unstable_cnt); end
        checks++; if (ch !== lfsr_adv(8'hA5, 16)) begin errors++; $display("[TB] FAIL ch0_ch_after: got %h want %h", ch, lfsr_adv(8'hA5, 16)); end
    endtask

    task automatic test_alternating();
        int c;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resp_mode = 2;
        pulse_start();
        wait_done(c);
        checks++; if (c != RUN_CYC) begin errors++; $display("[TB] FAIL alt_done_cycle: got %0d want %0d", c, RUN_CYC); end
        checks++; if (bus.resp_word !== 16'hFFFF) begin errors++; $display("[TB] FAIL alt_resp_word: got %h want ffff", bus.resp_word); end
        checks++; if (bus.unstable_cnt !== 5'd16) begin errors++; $display("[TB] FAIL alt_unstable: got %0d want 16", bus.unstable_cnt); end
    endtask

    task automatic test_seed_load();
        int c;
        resp_mode  = 0;
        resp_const = 1'b1;
        load_seed(8'h00);
        checks++; if (ch !== 8'h01) begin errors++; $display("[TB] FAIL seed_zero_sub: got %h want 01", ch); end
        @(negedge clk);
        bus.seed_load = 1'b1;
        bus.seed      = 8'h3C;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        bus.start     = 1'b0;
        checks++; if (ch !== 8'h3C) begin errors++; $display("[TB] FAIL seed_start_ch: got %h want 3c", ch); end
        repeat (50) @(negedge clk);
        checks++; if (ch !== 8'h3C) begin errors++; $display("[TB] FAIL seed_first_chal: got %h want 3c", ch); end
        wait_done(c);
        checks++; if (c < 0 || c + 50 != RUN_CYC) begin errors++; $display("[TB] FAIL seed_done_cycle: got %0d want %0d", (c < 0) ? c : c + 50, RUN_CYC); end
        checks++; if (ch !== lfsr_adv(8'h3C, 16)) begin errors++; $display("[TB] FAIL seed_ch_after: got %h want %h", ch, lfsr_adv(8'h3C, 16)); end
        checks++; if (bus.resp_word !== 16'hFFFF) begin errors++; $display("[TB] FAIL seed_resp_word: got %h want ffff", bus.resp_word); end
    endtask

    task automatic test_mid_run_reset();
        int c;
        int p0;
        resp_mode  = 0;
        resp_const = 1'b1;
        pulse_start();
        repeat (500) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mux_in !== 1'b0 || puf_rst !== 1'b1) begin errors++; $display("[TB] FAIL rst_pins: got mux_in=%b puf_rst=%b want 0/1", mux_in, puf_rst); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (ch !== 8'hA5) begin errors++; $display("[TB] FAIL rst_ch: got %h want a5", ch); end
        @(negedge clk);
        rst = 1'b0;
        p0 = done_pulses;
        repeat (1600) @(negedge clk);
        checks++; if (done_pulses != p0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_done: got pulses=%0d busy=%b want 0/0", done_pulses - p0, bus.busy); end
        pulse_start();
        wait_done(c);
        checks++; if (c != RUN_CYC) begin errors++; $display("[TB] FAIL rst_rerun_cycle: got %0d want %0d", c, RUN_CYC); end
        checks++; if (bus.resp_word !== 16'hFFFF) begin errors++; $display("[TB] FAIL rst_rerun_word: got %h want ffff", bus.resp_word); end
    endtask

    task automatic test_busy_ignore();
        int c;
        int got;
        logic [15:0] exp_word;
        resp_mode = 1;
        exp_word  = ch0_word(8'hA5);
        load_seed(8'hA5);
        pulse_start();
        c = 0;
        got = -1;
        while (c < RUN_CYC + 100 && got < 0) begin
            @(negedge clk);
            c++;
            bus.start     = (c == 100);
            bus.seed_load = (c == 200);
            bus.seed      = (c == 200) ? 8'h3C : 8'h00;
            if (c == 201) begin
                checks++; if (ch !== lfsr_adv(8'hA5, 2)) begin errors++; $display("[TB] FAIL busy_ch_mid: got %h want %h", ch, lfsr_adv(8'hA5, 2)); end
            end
            if (bus.done) got = c;
        end
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        checks++; if (got != RUN_CYC) begin errors++; $display("[TB] FAIL busy_done_cycle: got %0d want %0d", got, RUN_CYC); end
        checks++; if (bus.resp_word !== exp_word) begin errors++; $display("[TB] FAIL busy_resp_word: got %h want %h", bus.resp_word, exp_word); end
        checks++; if (ch !== lfsr_adv(8'hA5, 16)) begin errors++; $display("[TB] FAIL busy_ch_after: got %h want %h", ch, lfsr_adv(8'hA5, 16)); end
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_restart: got %b want 0", bus.busy); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 8'h00;
        test_reset();
        test_all_ones();
        test_ch0_model();
        test_alternating();
        test_seed_load();
        test_mid_run_reset();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
